// File: rtl/wb_arbiter.sv
// Writeback arbiter: one holding slot per functional-unit result port and a
// round-robin arbiter that forwards one held result per cycle to the single
// scoreboard writeback port. A presented grant stays locked while stalled so
// the payload remains stable under valid/ready handshaking.

package wb_arbiter_pkg;
  typedef struct packed {
    logic        valid;
    logic [5:0]  cause;
    logic [31:0] tval;
  } exception_t;

  typedef struct packed {
    logic [2:0]  index;
    logic [4:0]  rd;
    logic [31:0] result;
    exception_t  ex;
  } fu_result_t;
endpackage

module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter  int NUM_FU   = 3,
  localparam int FU_IDX_W = $clog2(NUM_FU)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic       [NUM_FU-1:0]      fu_result_valid_i,
  output logic       [NUM_FU-1:0]      fu_result_ready_o,
  input  fu_result_t [NUM_FU-1:0]      fu_result_i,
  output logic                         wb_valid_o,
  input  logic                         wb_ready_i,
  output fu_result_t                   wb_result_o,
  output logic       [FU_IDX_W-1:0]    wb_fu_o
);

  logic       [NUM_FU-1:0]   full_q, full_d;
  fu_result_t [NUM_FU-1:0]   slot_q, slot_d;
  logic       [FU_IDX_W-1:0] rr_q, rr_d;
  logic       [FU_IDX_W-1:0] lock_fu_q, lock_fu_d;
  logic                      lock_q, lock_d;

  logic       [FU_IDX_W-1:0] grant_s;
  logic       [FU_IDX_W:0]   cand_s;
  logic                      found_s;
  logic                      wb_valid_s;
  logic                      pop_s;
  logic       [NUM_FU-1:0]   pop_vec_s;
  logic       [NUM_FU-1:0]   ready_s;
  logic       [NUM_FU-1:0]   push_s;

  // Grant selection: hold the locked FU while stalled, else first full slot after rr_q.
  always_comb begin
    grant_s = '0;
    found_s = 1'b0;
    cand_s  = '0;
    if (lock_q) begin
      grant_s = lock_fu_q;
    end else begin
      for (int k = 1; k <= NUM_FU; k++) begin
        cand_s = {1'b0, rr_q} + (FU_IDX_W + 1)'(k);
        if (cand_s >= (FU_IDX_W + 1)'(NUM_FU)) begin
          cand_s = cand_s - (FU_IDX_W + 1)'(NUM_FU);
        end else begin
          cand_s = cand_s;
        end
        if (!found_s && full_q[cand_s[FU_IDX_W-1:0]]) begin
          grant_s = cand_s[FU_IDX_W-1:0];
          found_s = 1'b1;
        end else begin
          found_s = found_s;
        end
      end
    end
  end

  // Handshake terms: pop of the granted slot, per-FU ready (can reload on a pop), pushes.
  always_comb begin
    wb_valid_s = |full_q;
    pop_s      = wb_valid_s & wb_ready_i;
    pop_vec_s  = '0;
    ready_s    = '0;
    push_s     = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      pop_vec_s[i] = pop_s & (grant_s == FU_IDX_W'(i));
      ready_s[i]   = ~flush_i & (~full_q[i] | pop_vec_s[i]);
      push_s[i]    = fu_result_valid_i[i] & ready_s[i];
    end
  end

  // Next-state for slots, round-robin pointer and stall lock.
  always_comb begin
    full_d    = full_q;
    slot_d    = slot_q;
    rr_d      = rr_q;
    lock_d    = lock_q;
    lock_fu_d = lock_fu_q;
    for (int i = 0; i < NUM_FU; i++) begin
      if (push_s[i]) begin
        full_d[i] = 1'b1;
        slot_d[i] = fu_result_i[i];
      end else if (pop_vec_s[i]) begin
        full_d[i] = 1'b0;
      end else begin
        full_d[i] = full_q[i];
      end
    end
    if (pop_s) begin
      rr_d = grant_s;
    end else begin
      rr_d = rr_q;
    end
    if (flush_i) begin
      full_d = '0;
      lock_d = 1'b0;
    end else if (pop_s) begin
      lock_d = 1'b0;
    end else if (wb_valid_s) begin
      lock_d    = 1'b1;
      lock_fu_d = grant_s;
    end else begin
      lock_d = lock_q;
    end
  end

  // State registers; reset points rr at the last FU so FU0 wins first.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q    <= '0;
      slot_q    <= '0;
      rr_q      <= FU_IDX_W'(NUM_FU - 1);
      lock_q    <= 1'b0;
      lock_fu_q <= '0;
    end else begin
      full_q    <= full_d;
      slot_q    <= slot_d;
      rr_q      <= rr_d;
      lock_q    <= lock_d;
      lock_fu_q <= lock_fu_d;
    end
  end

  assign fu_result_ready_o = ready_s;
  assign wb_valid_o        = wb_valid_s;
  assign wb_result_o       = wb_valid_s ? slot_q[grant_s] : '0;
  assign wb_fu_o           = wb_valid_s ? grant_s : '0;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a driver applies directed and random
// traffic and pushes the expected writeback view of each cycle, computed
// from an abstract slot/round-robin model; a monitor pops and compares.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int NUM_FU   = 3;
  localparam int FU_IDX_W = $clog2(NUM_FU);

  logic                      clk_i = 1'b0;
  logic                      rst_ni = 1'b1;
  logic                      flush_i = 1'b0;
  logic       [NUM_FU-1:0]   fu_result_valid_i = '0;
  logic       [NUM_FU-1:0]   fu_result_ready_o;
  fu_result_t [NUM_FU-1:0]   fu_result_i = '0;
  logic                      wb_valid_o;
  logic                      wb_ready_i = 1'b0;
  fu_result_t                wb_result_o;
  logic       [FU_IDX_W-1:0] wb_fu_o;

  wb_arbiter #(.NUM_FU(NUM_FU)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .fu_result_valid_i(fu_result_valid_i), .fu_result_ready_o(fu_result_ready_o),
    .fu_result_i(fu_result_i), .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_result_o(wb_result_o), .wb_fu_o(wb_fu_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          v;
    int          fu;
    fu_result_t  res;
    bit [NUM_FU-1:0] rdy;
  } exp_t;

  exp_t exp_q[$];
  int   n_err = 0;
  int   n_chk = 0;

  // Abstract model: which FUs hold a result, what they hold, last winner, held grant.
  bit          m_full[NUM_FU];
  fu_result_t  m_slot[NUM_FU];
  int          m_rr;
  int          m_held;
  fu_result_t [NUM_FU-1:0] pld;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_FU; i++) begin
      m_full[i] = 1'b0;
      m_slot[i] = '0;
    end
    m_rr   = NUM_FU - 1;
    m_held = -1;
  endtask

  task automatic rand_pld();
    logic [95:0] r96;
    for (int i = 0; i < NUM_FU; i++) begin
      r96    = {$urandom, $urandom, $urandom};
      pld[i] = r96[$bits(fu_result_t)-1:0];
    end
  endtask

  // One cycle of stimulus plus the model's expectation for that cycle.
  task automatic step(input logic [NUM_FU-1:0] v, input logic r, input logic f);
    exp_t e;
    int   g;
    bit   val;
    bit   popv;
    bit [NUM_FU-1:0] rdy;
    @(negedge clk_i);
    fu_result_valid_i = v;
    wb_ready_i        = r;
    flush_i           = f;
    fu_result_i       = pld;
    val = 1'b0;
    for (int i = 0; i < NUM_FU; i++) if (m_full[i]) val = 1'b1;
    g = 0;
    if (m_held >= 0) g = m_held;
    else begin
      for (int k = 1; k <= NUM_FU; k++) begin
        if (m_full[(m_rr + k) % NUM_FU]) begin
          g = (m_rr + k) % NUM_FU;
          break;
        end
      end
    end
    popv = val && r;
    for (int i = 0; i < NUM_FU; i++) rdy[i] = !f && (!m_full[i] || (popv && g == i));
    e.v   = val;
    e.fu  = val ? g : 0;
    e.res = val ? m_slot[g] : '0;
    e.rdy = rdy;
    exp_q.push_back(e);
    for (int i = 0; i < NUM_FU; i++) begin
      if (v[i] && rdy[i]) begin
        m_slot[i] = pld[i];
        m_full[i] = 1'b1;
      end else if (popv && g == i) begin
        m_full[i] = 1'b0;
      end
      if (f) m_full[i] = 1'b0;
    end
    if (popv) m_rr = g;
    if (f || popv) m_held = -1;
    else if (val) m_held = g;
  endtask

  // Asynchronous reset mid-cycle; outputs must drop immediately.
  task automatic do_reset();
    @(negedge clk_i);
    #3;
    fu_result_valid_i = '0;
    flush_i           = 1'b0;
    wb_ready_i        = 1'b0;
    rst_ni            = 1'b0;
    #1;
    chk("rst_valid", 128'(wb_valid_o), 128'(1'b0));
    chk("rst_fu", 128'(wb_fu_o), 128'(0));
    chk("rst_result", 128'(wb_result_o), 128'(0));
    chk("rst_ready", 128'(fu_result_ready_o), 128'({NUM_FU{1'b1}}));
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  // Monitor: compare DUT outputs against the queued expectation each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wb_valid", 128'(wb_valid_o), 128'(e.v));
        chk("fu_ready", 128'(fu_result_ready_o), 128'(e.rdy));
        chk("wb_fu", 128'(wb_fu_o), 128'(e.fu));
        chk("wb_result", 128'(wb_result_o), 128'(e.res));
      end
    end
  end

  initial begin
    model_reset();
    pld = '0;
    do_reset();

    // FU0 streaming, always ready
    for (int n = 0; n < 6; n++) begin
      rand_pld();
      pld[0].index  = 3'(n);
      pld[0].rd     = 5'd5;
      pld[0].result = 32'h10 + 32'(n);
      step(3'b001, 1'b1, 1'b0);
    end
    step(3'b000, 1'b1, 1'b0);
    step(3'b000, 1'b1, 1'b0);

    // Round-robin order from reset
    do_reset();
    rand_pld(); step(3'b111, 1'b1, 1'b0);
    step(3'b000, 1'b1, 1'b0); step(3'b000, 1'b1, 1'b0); step(3'b000, 1'b1, 1'b0);
    rand_pld(); step(3'b111, 1'b1, 1'b0);
    step(3'b000, 1'b1, 1'b0); step(3'b000, 1'b1, 1'b0); step(3'b000, 1'b1, 1'b0);

    // FU1 wins, stall while FU0 fills
    rand_pld(); step(3'b010, 1'b0, 1'b0);
    rand_pld(); step(3'b001, 1'b0, 1'b0);
    step(3'b000, 1'b0, 1'b0); step(3'b000, 1'b0, 1'b0); step(3'b000, 1'b0, 1'b0);
    step(3'b000, 1'b1, 1'b0); step(3'b000, 1'b1, 1'b0); step(3'b000, 1'b1, 1'b0);

    // Slot0 stalled then back-to-back reload on pop
    rand_pld(); step(3'b001, 1'b0, 1'b0);
    rand_pld(); step(3'b001, 1'b0, 1'b0);
    rand_pld(); step(3'b001, 1'b1, 1'b0);
    step(3'b000, 1'b1, 1'b0); step(3'b000, 1'b1, 1'b0);

    // Flush with slots 0,2 full and FU1 offering
    rand_pld(); step(3'b101, 1'b0, 1'b0);
    rand_pld(); step(3'b010, 1'b0, 1'b1);
    step(3'b000, 1'b1, 1'b0);
    rand_pld(); step(3'b111, 1'b1, 1'b0);
    step(3'b000, 1'b1, 1'b0); step(3'b000, 1'b1, 1'b0); step(3'b000, 1'b1, 1'b0);

    // Reset during a stall with all slots full
    rand_pld(); step(3'b111, 1'b0, 1'b0);
    step(3'b000, 1'b0, 1'b0);
    do_reset();
    step(3'b000, 1'b1, 1'b0);
    rand_pld(); step(3'b111, 1'b1, 1'b0);
    step(3'b000, 1'b1, 1'b0); step(3'b000, 1'b1, 1'b0); step(3'b000, 1'b1, 1'b0);

    // Random traffic
    for (int n = 0; n < 500; n++) begin
      rand_pld();
      step(3'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
    end
    for (int n = 0; n < 4; n++) step(3'b000, 1'b1, 1'b0);

    @(negedge clk_i);
    #5;
    chk("sb_drained", 128'(exp_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
